// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave front-end that turns bus transactions into register-file
// port accesses: a word-addressed write port (wa/wd/we) and a read port (ra/rd).
// One outstanding write and one outstanding read; 32-bit data only.
// Optional macro AXI_REG_SLVERR_EN: when defined, out-of-range addresses return
// SLVERR, are never written and read as zero; when undefined, the upper address
// bits are ignored, the offset aliases into the register file and every
// response is OKAY.
module axi_lite_reg_slave #(
    parameter int NumWords  = 64,
    parameter int AddrWidth = 12
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [AddrWidth-1:0]           s_awaddr,
    input  logic                           s_awvalid,
    output logic                           s_awready,
    input  logic [31:0]                    s_wdata,
    input  logic [3:0]                     s_wstrb,
    input  logic                           s_wvalid,
    output logic                           s_wready,
    output logic [1:0]                     s_bresp,
    output logic                           s_bvalid,
    input  logic                           s_bready,
    input  logic [AddrWidth-1:0]           s_araddr,
    input  logic                           s_arvalid,
    output logic                           s_arready,
    output logic [31:0]                    s_rdata,
    output logic [1:0]                     s_rresp,
    output logic                           s_rvalid,
    input  logic                           s_rready,
    output logic [$clog2(NumWords)-1:0]    wa,
    output logic [31:0]                    wd,
    output logic [3:0]                     we,
    output logic [$clog2(NumWords)-1:0]    ra,
    input  logic [31:0]                    rd
);

    localparam int OffsetWidth = $clog2(NumWords);

`ifdef AXI_REG_SLVERR_EN
    localparam logic SlvErrEn = 1'b1;
`else
    localparam logic SlvErrEn = 1'b0;
`endif

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;

    // Write-side buffers and response state
    logic                   r_awFull;
    logic [OffsetWidth-1:0] r_awOffset;
    logic                   r_awInRange;
    logic                   r_wFull;
    logic [31:0]            r_wData;
    logic [3:0]             r_wStrb;
    logic                   r_bvalid;
    logic [1:0]             r_bresp;

    // Read-side buffer and response state
    logic                   r_arFull;
    logic [OffsetWidth-1:0] r_arOffset;
    logic                   r_arInRange;
    logic                   r_rvalid;
    logic [31:0]            r_rdata;
    logic [1:0]             r_rresp;

    logic w_awAccept;
    logic w_wAccept;
    logic w_arAccept;
    logic w_issue;
    logic w_awInRange;
    logic w_arInRange;
    logic w_unusedAddrBits;

    // Buffers accept whenever empty; a read also waits for the previous R handshake.
    assign w_awAccept = s_awvalid & ~r_awFull;
    assign w_wAccept  = s_wvalid & ~r_wFull;
    assign w_arAccept = s_arvalid & ~r_arFull & ~r_rvalid;

    // A write issues once both halves are buffered and no B response is pending.
    assign w_issue = r_awFull & r_wFull & ~r_bvalid;

    // With error reporting disabled every address counts as in range, so the
    // offset simply aliases into the register file.
    assign w_awInRange = (s_awaddr[AddrWidth-1:OffsetWidth+2] == '0) | ~SlvErrEn;
    assign w_arInRange = (s_araddr[AddrWidth-1:OffsetWidth+2] == '0) | ~SlvErrEn;

    // Byte-lane bits are ignored: unaligned accesses are treated as aligned.
    assign w_unusedAddrBits = ^{s_awaddr[1:0], s_araddr[1:0]};

    assign s_awready = ~r_awFull;
    assign s_wready  = ~r_wFull;
    assign s_arready = ~r_arFull & ~r_rvalid;
    assign s_bvalid  = r_bvalid;
    assign s_bresp   = r_bresp;
    assign s_rvalid  = r_rvalid;
    assign s_rdata   = r_rdata;
    assign s_rresp   = r_rresp;

    assign wa = r_awOffset;
    assign wd = r_wData;
    assign we = (w_issue & r_awInRange) ? r_wStrb : 4'b0000;
    assign ra = r_arOffset;

    // AW buffer: capture the decoded offset on accept, release on issue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_awFull    <= 1'b0;
            r_awOffset  <= '0;
            r_awInRange <= 1'b0;
        end else if (w_awAccept) begin
            r_awFull    <= 1'b1;
            r_awOffset  <= s_awaddr[OffsetWidth+1:2];
            r_awInRange <= w_awInRange;
        end else if (w_issue) begin
            r_awFull <= 1'b0;
        end
    end

    // W buffer: capture data and strobes on accept, release on issue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wFull <= 1'b0;
            r_wData <= '0;
            r_wStrb <= '0;
        end else if (w_wAccept) begin
            r_wFull <= 1'b1;
            r_wData <= s_wdata;
            r_wStrb <= s_wstrb;
        end else if (w_issue) begin
            r_wFull <= 1'b0;
        end
    end

    // B channel: raise the response on the issue edge, hold it until bready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bvalid <= 1'b0;
            r_bresp  <= RespOkay;
        end else if (w_issue) begin
            r_bvalid <= 1'b1;
            r_bresp  <= r_awInRange ? RespOkay : RespSlvErr;
        end else if (r_bvalid & s_bready) begin
            r_bvalid <= 1'b0;
        end
    end

    // AR buffer: holds ra stable for one cycle, then clears on the sampling edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_arFull    <= 1'b0;
            r_arOffset  <= '0;
            r_arInRange <= 1'b0;
        end else if (w_arAccept) begin
            r_arFull    <= 1'b1;
            r_arOffset  <= s_araddr[OffsetWidth+1:2];
            r_arInRange <= w_arInRange;
        end else if (r_arFull) begin
            r_arFull <= 1'b0;
        end
    end

    // R channel: sample rd while the AR buffer is full, hold until rready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RespOkay;
        end else if (r_arFull) begin
            r_rvalid <= 1'b1;
            r_rdata  <= r_arInRange ? rd : 32'h0;
            r_rresp  <= r_arInRange ? RespOkay : RespSlvErr;
        end else if (r_rvalid & s_rready) begin
            r_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed testbench for axi_lite_reg_slave with a behavioural register file
// attached to the wa/wd/we and ra/rd ports. Expected values are hand-computed.
// Expectations for out-of-range accesses follow AXI_REG_SLVERR_EN.
module tb_axi_lite_reg_slave;

    localparam int NumWords    = 64;
    localparam int AddrWidth   = 12;
    localparam int OffsetWidth = 6;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic [AddrWidth-1:0]   s_awaddr;
    logic                   s_awvalid;
    logic                   s_awready;
    logic [31:0]            s_wdata;
    logic [3:0]             s_wstrb;
    logic                   s_wvalid;
    logic                   s_wready;
    logic [1:0]             s_bresp;
    logic                   s_bvalid;
    logic                   s_bready;
    logic [AddrWidth-1:0]   s_araddr;
    logic                   s_arvalid;
    logic                   s_arready;
    logic [31:0]            s_rdata;
    logic [1:0]             s_rresp;
    logic                   s_rvalid;
    logic                   s_rready;
    logic [OffsetWidth-1:0] wa;
    logic [31:0]            wd;
    logic [3:0]             we;
    logic [OffsetWidth-1:0] ra;
    logic [31:0]            rd;

    logic [31:0] regFile [NumWords];

    int checkCount = 0;
    int errorCount = 0;

    axi_lite_reg_slave #(.NumWords(NumWords), .AddrWidth(AddrWidth)) dut (
        .clk(clk), .reset_n(reset_n),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .wa(wa), .wd(wd), .we(we), .ra(ra), .rd(rd)
    );

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    // Behavioural register file: byte-enabled write on the clock edge
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) regFile[wa][8*b +: 8] <= wd[8*b +: 8];
        end
    end

    // Combinational read port
    assign rd = regFile[ra];

    // Drives an AR and waits for the R response, then completes the handshake
    task automatic axiRead(input logic [AddrWidth-1:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output bit gotIt);
        bit accepted = 0;
        bit responded = 0;
        s_araddr  = addr;
        s_arvalid = 1'b1;
        for (int i = 0; i < 20 && !accepted; i++) begin
            if (s_arready) accepted = 1;
            @(negedge clk);
        end
        s_arvalid = 1'b0;
        for (int i = 0; i < 20 && !responded; i++) begin
            @(negedge clk);
            if (s_rvalid) responded = 1;
        end
        data  = s_rdata;
        resp  = s_rresp;
        gotIt = accepted & responded;
        s_rready = 1'b1;
        @(negedge clk);
        s_rready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        checkCount++; if (s_awready !== 1'b1) begin errorCount++; $display("[TB] FAIL reset_awready got %b exp 1", s_awready); end
        checkCount++; if (s_wready !== 1'b1) begin errorCount++; $display("[TB] FAIL reset_wready got %b exp 1", s_wready); end
        checkCount++; if (s_arready !== 1'b1) begin errorCount++; $display("[TB] FAIL reset_arready got %b exp 1", s_arready); end
        checkCount++; if (s_bvalid !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_bvalid got %b exp 0", s_bvalid); end
        checkCount++; if (s_rvalid !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_rvalid got %b exp 0", s_rvalid); end
        checkCount++; if (s_bresp !== 2'b00) begin errorCount++; $display("[TB] FAIL reset_bresp got %b exp 00", s_bresp); end
        checkCount++; if (s_rresp !== 2'b00) begin errorCount++; $display("[TB] FAIL reset_rresp got %b exp 00", s_rresp); end
        checkCount++; if (s_rdata !== 32'h0) begin errorCount++; $display("[TB] FAIL reset_rdata got %h exp 0", s_rdata); end
        checkCount++; if (we !== 4'h0) begin errorCount++; $display("[TB] FAIL reset_we got %h exp 0", we); end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_same_cycle_write();
        logic [31:0] rdVal;
        logic [1:0]  rsVal;
        bit          ok;
        s_awaddr = 12'h010; s_awvalid = 1'b1;
        s_wdata = 32'hDEADBEEF; s_wstrb = 4'hF; s_wvalid = 1'b1;
        @(negedge clk);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        checkCount++; if (we !== 4'hF) begin errorCount++; $display("[TB] FAIL sc_we got %h exp f", we); end
        checkCount++; if (wa !== 6'd4) begin errorCount++; $display("[TB] FAIL sc_wa got %0d exp 4", wa); end
        checkCount++; if (wd !== 32'hDEADBEEF) begin errorCount++; $display("[TB] FAIL sc_wd got %h exp deadbeef", wd); end
        checkCount++; if (s_bvalid !== 1'b0) begin errorCount++; $display("[TB] FAIL sc_bvalid_early got %b exp 0", s_bvalid); end
        @(negedge clk);
        checkCount++; if (we !== 4'h0) begin errorCount++; $display("[TB] FAIL sc_we_once got %h exp 0", we); end
        checkCount++; if (s_bvalid !== 1'b1) begin errorCount++; $display("[TB] FAIL sc_bvalid got %b exp 1", s_bvalid); end
        checkCount++; if (s_bresp !== 2'b00) begin errorCount++; $display("[TB] FAIL sc_bresp got %b exp 00", s_bresp); end
        s_bready = 1'b1;
        @(negedge clk);
        s_bready = 1'b0;
        checkCount++; if (s_bvalid !== 1'b0) begin errorCount++; $display("[TB] FAIL sc_bvalid_clear got %b exp 0", s_bvalid); end
        s_araddr = 12'h010; s_arvalid = 1'b1;
        @(negedge clk);
        s_arvalid = 1'b0;
        checkCount++; if (ra !== 6'd4) begin errorCount++; $display("[TB] FAIL sc_ra got %0d exp 4", ra); end
        checkCount++; if (s_rvalid !== 1'b0) begin errorCount++; $display("[TB] FAIL sc_rvalid_early got %b exp 0", s_rvalid); end
        @(negedge clk);
        checkCount++; if (s_rvalid !== 1'b1) begin errorCount++; $display("[TB] FAIL sc_rvalid got %b exp 1", s_rvalid); end
        checkCount++; if (s_rdata !== 32'hDEADBEEF) begin errorCount++; $display("[TB] FAIL sc_rdata got %h exp deadbeef", s_rdata); end
        checkCount++; if (s_rresp !== 2'b00) begin errorCount++; $display("[TB] FAIL sc_rresp got %b exp 00", s_rresp); end
        s_rready = 1'b1;
        @(negedge clk);
        s_rready = 1'b0;
        checkCount++; if (s_rvalid !== 1'b0) begin errorCount++; $display("[TB] FAIL sc_rvalid_clear got %b exp 0", s_rvalid); end
        axiRead(12'h014, rdVal, rsVal, ok);
        checkCount++; if (ok !== 1'b1) begin errorCount++; $display("[TB] FAIL sc_neighbour_timeout got %b exp 1", ok); end
        checkCount++; if (rdVal !== 32'h0) begin errorCount++; $display("[TB] FAIL sc_neighbour_rdata got %h exp 0", rdVal); end
    endtask

    task automatic test_w_before_aw();
        logic [31:0] rdVal;
        logic [1:0]  rsVal;
        bit          ok;
        s_wdata = 32'h11223344; s_wstrb = 4'h5; s_wvalid = 1'b1;
        @(negedge clk);
        s_wvalid = 1'b0;
        checkCount++; if (s_wready !== 1'b0) begin errorCount++; $display("[TB] FAIL wfirst_wready got %b exp 0", s_wready); end
        checkCount++; if (we !== 4'h0) begin errorCount++; $display("[TB] FAIL wfirst_we0 got %h exp 0", we); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkCount++; if (we !== 4'h0) begin errorCount++; $display("[TB] FAIL wfirst_we_wait%0d got %h exp 0", i, we); end
        end
        s_awaddr = 12'h004; s_awvalid = 1'b1;
        @(negedge clk);
        s_awvalid = 1'b0;
        checkCount++; if (we !== 4'h5) begin errorCount++; $display("[TB] FAIL wfirst_we got %h exp 5", we); end
        checkCount++; if (wa !== 6'd1) begin errorCount++; $display("[TB] FAIL wfirst_wa got %0d exp 1", wa); end
        @(negedge clk);
        checkCount++; if (we !== 4'h0) begin errorCount++; $display("[TB] FAIL wfirst_we_once got %h exp 0", we); end
        checkCount++; if (s_bvalid !== 1'b1) begin errorCount++; $display("[TB] FAIL wfirst_bvalid got %b exp 1", s_bvalid); end
        s_bready = 1'b1;
        @(negedge clk);
        s_bready = 1'b0;
        axiRead(12'h004, rdVal, rsVal, ok);
        checkCount++; if (ok !== 1'b1) begin errorCount++; $display("[TB] FAIL wfirst_read_timeout got %b exp 1", ok); end
        checkCount++; if (rdVal !== 32'h00220044) begin errorCount++; $display("[TB] FAIL wfirst_rdata got %h exp 00220044", rdVal); end
    endtask

    task automatic test_backpressure_b();
        s_awaddr = 12'h020; s_awvalid = 1'b1;
        s_wdata = 32'hAAAA5555; s_wstrb = 4'hF; s_wvalid = 1'b1;
        @(negedge clk);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        checkCount++; if (we !== 4'hF) begin errorCount++; $display("[TB] FAIL bp1_we got %h exp f", we); end
        checkCount++; if (wa !== 6'd8) begin errorCount++; $display("[TB] FAIL bp1_wa got %0d exp 8", wa); end
        @(negedge clk);
        checkCount++; if (s_bvalid !== 1'b1) begin errorCount++; $display("[TB] FAIL bp1_bvalid got %b exp 1", s_bvalid); end
        s_awaddr = 12'h024; s_awvalid = 1'b1;
        s_wdata = 32'h12345678; s_wstrb = 4'hF; s_wvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            s_awvalid = 1'b0; s_wvalid = 1'b0;
            checkCount++; if (we !== 4'h0) begin errorCount++; $display("[TB] FAIL bp_hold_we%0d got %h exp 0", i, we); end
            checkCount++; if (s_bvalid !== 1'b1) begin errorCount++; $display("[TB] FAIL bp_hold_bvalid%0d got %b exp 1", i, s_bvalid); end
        end
        checkCount++; if (s_awready !== 1'b0) begin errorCount++; $display("[TB] FAIL bp_awready_full got %b exp 0", s_awready); end
        s_bready = 1'b1;
        @(negedge clk);
        s_bready = 1'b0;
        checkCount++; if (s_bvalid !== 1'b0) begin errorCount++; $display("[TB] FAIL bp1_bvalid_clear got %b exp 0", s_bvalid); end
        checkCount++; if (we !== 4'hF) begin errorCount++; $display("[TB] FAIL bp2_we got %h exp f", we); end
        checkCount++; if (wa !== 6'd9) begin errorCount++; $display("[TB] FAIL bp2_wa got %0d exp 9", wa); end
        @(negedge clk);
        checkCount++; if (s_bvalid !== 1'b1) begin errorCount++; $display("[TB] FAIL bp2_bvalid got %b exp 1", s_bvalid); end
        checkCount++; if (we !== 4'h0) begin errorCount++; $display("[TB] FAIL bp2_we_once got %h exp 0", we); end
        s_bready = 1'b1;
        @(negedge clk);
        s_bready = 1'b0;
    endtask

    task automatic test_backpressure_r();
        s_araddr = 12'h020; s_arvalid = 1'b1;
        @(negedge clk);
        s_arvalid = 1'b0;
        @(negedge clk);
        s_araddr = 12'h024; s_arvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkCount++; if (s_rvalid !== 1'b1) begin errorCount++; $display("[TB] FAIL rbp_rvalid%0d got %b exp 1", i, s_rvalid); end
            checkCount++; if (s_rdata !== 32'hAAAA5555) begin errorCount++; $display("[TB] FAIL rbp_rdata%0d got %h exp aaaa5555", i, s_rdata); end
            checkCount++; if (s_arready !== 1'b0) begin errorCount++; $display("[TB] FAIL rbp_arready%0d got %b exp 0", i, s_arready); end
            @(negedge clk);
        end
        s_rready = 1'b1;
        @(negedge clk);
        s_rready = 1'b0;
        checkCount++; if (s_rvalid !== 1'b0) begin errorCount++; $display("[TB] FAIL rbp_rvalid_clear got %b exp 0", s_rvalid); end
        checkCount++; if (s_arready !== 1'b1) begin errorCount++; $display("[TB] FAIL rbp_arready_back got %b exp 1", s_arready); end
        @(negedge clk);
        s_arvalid = 1'b0;
        checkCount++; if (ra !== 6'd9) begin errorCount++; $display("[TB] FAIL rbp_ra2 got %0d exp 9", ra); end
        @(negedge clk);
        checkCount++; if (s_rvalid !== 1'b1) begin errorCount++; $display("[TB] FAIL rbp_rvalid2 got %b exp 1", s_rvalid); end
        checkCount++; if (s_rdata !== 32'h12345678) begin errorCount++; $display("[TB] FAIL rbp_rdata2 got %h exp 12345678", s_rdata); end
        s_rready = 1'b1;
        @(negedge clk);
        s_rready = 1'b0;
    endtask

    task automatic test_out_of_range();
        logic [31:0] rdVal;
        logic [1:0]  rsVal;
        bit          ok;
        s_awaddr = 12'h400; s_awvalid = 1'b1;
        s_wdata = 32'hCAFEF00D; s_wstrb = 4'hF; s_wvalid = 1'b1;
        @(negedge clk);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
`ifdef AXI_REG_SLVERR_EN
        checkCount++; if (we !== 4'h0) begin errorCount++; $display("[TB] FAIL oor_we got %h exp 0", we); end
`else
        checkCount++; if (we !== 4'hF) begin errorCount++; $display("[TB] FAIL oor_we got %h exp f", we); end
        checkCount++; if (wa !== 6'd0) begin errorCount++; $display("[TB] FAIL oor_wa got %0d exp 0", wa); end
`endif
        @(negedge clk);
        checkCount++; if (s_bvalid !== 1'b1) begin errorCount++; $display("[TB] FAIL oor_bvalid got %b exp 1", s_bvalid); end
`ifdef AXI_REG_SLVERR_EN
        checkCount++; if (s_bresp !== 2'b10) begin errorCount++; $display("[TB] FAIL oor_bresp got %b exp 10", s_bresp); end
`else
        checkCount++; if (s_bresp !== 2'b00) begin errorCount++; $display("[TB] FAIL oor_bresp got %b exp 00", s_bresp); end
`endif
        s_bready = 1'b1;
        @(negedge clk);
        s_bready = 1'b0;
        axiRead(12'h400, rdVal, rsVal, ok);
        checkCount++; if (ok !== 1'b1) begin errorCount++; $display("[TB] FAIL oor_read_timeout got %b exp 1", ok); end
`ifdef AXI_REG_SLVERR_EN
        checkCount++; if (rsVal !== 2'b10) begin errorCount++; $display("[TB] FAIL oor_rresp got %b exp 10", rsVal); end
        checkCount++; if (rdVal !== 32'h0) begin errorCount++; $display("[TB] FAIL oor_rdata got %h exp 0", rdVal); end
`else
        checkCount++; if (rsVal !== 2'b00) begin errorCount++; $display("[TB] FAIL oor_rresp got %b exp 00", rsVal); end
        checkCount++; if (rdVal !== 32'hCAFEF00D) begin errorCount++; $display("[TB] FAIL oor_rdata got %h exp cafef00d", rdVal); end
`endif
        axiRead(12'h000, rdVal, rsVal, ok);
        checkCount++; if (ok !== 1'b1) begin errorCount++; $display("[TB] FAIL oor_word0_timeout got %b exp 1", ok); end
`ifdef AXI_REG_SLVERR_EN
        checkCount++; if (rdVal !== 32'h0) begin errorCount++; $display("[TB] FAIL oor_word0 got %h exp 0", rdVal); end
`else
        checkCount++; if (rdVal !== 32'hCAFEF00D) begin errorCount++; $display("[TB] FAIL oor_word0 got %h exp cafef00d", rdVal); end
`endif
    endtask

    task automatic test_reset_midflight();
        logic [31:0] rdVal;
        logic [1:0]  rsVal;
        bit          ok;
        s_awaddr = 12'h030; s_awvalid = 1'b1;
        s_wdata = 32'hFEEDFACE; s_wstrb = 4'hF; s_wvalid = 1'b1;
        @(negedge clk);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        @(negedge clk);
        s_awaddr = 12'h034; s_awvalid = 1'b1;
        s_wdata = 32'h0BADBEEF; s_wvalid = 1'b1;
        @(negedge clk);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        checkCount++; if (s_bvalid !== 1'b1) begin errorCount++; $display("[TB] FAIL rmf_pre_bvalid got %b exp 1", s_bvalid); end
        checkCount++; if (s_awready !== 1'b0) begin errorCount++; $display("[TB] FAIL rmf_pre_awready got %b exp 0", s_awready); end
        reset_n = 1'b0;
        #1;
        checkCount++; if (s_awready !== 1'b1) begin errorCount++; $display("[TB] FAIL rmf_awready got %b exp 1", s_awready); end
        checkCount++; if (s_wready !== 1'b1) begin errorCount++; $display("[TB] FAIL rmf_wready got %b exp 1", s_wready); end
        checkCount++; if (s_bvalid !== 1'b0) begin errorCount++; $display("[TB] FAIL rmf_bvalid got %b exp 0", s_bvalid); end
        checkCount++; if (we !== 4'h0) begin errorCount++; $display("[TB] FAIL rmf_we got %h exp 0", we); end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkCount++; if (we !== 4'h0) begin errorCount++; $display("[TB] FAIL rmf_we_after%0d got %h exp 0", i, we); end
            checkCount++; if (s_bvalid !== 1'b0) begin errorCount++; $display("[TB] FAIL rmf_bvalid_after%0d got %b exp 0", i, s_bvalid); end
        end
        axiRead(12'h034, rdVal, rsVal, ok);
        checkCount++; if (ok !== 1'b1) begin errorCount++; $display("[TB] FAIL rmf_read_timeout got %b exp 1", ok); end
        checkCount++; if (rdVal !== 32'h0) begin errorCount++; $display("[TB] FAIL rmf_dropped_word got %h exp 0", rdVal); end
        axiRead(12'h030, rdVal, rsVal, ok);
        checkCount++; if (rdVal !== 32'hFEEDFACE) begin errorCount++; $display("[TB] FAIL rmf_committed_word got %h exp feedface", rdVal); end
    endtask

    // Watchdog so a stuck run still terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout exp completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence
    initial begin
        for (int i = 0; i < NumWords; i++) regFile[i] = 32'h0;
        reset_n   = 1'b0;
        s_awaddr  = '0; s_awvalid = 1'b0;
        s_wdata   = '0; s_wstrb   = '0; s_wvalid = 1'b0;
        s_bready  = 1'b0;
        s_araddr  = '0; s_arvalid = 1'b0;
        s_rready  = 1'b0;
        test_reset();
        test_same_cycle_write();
        test_w_before_aw();
        test_backpressure_b();
        test_backpressure_r();
        test_out_of_range();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
